// File: rtl/wb_commit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_buffer
// Purpose  : Multi-lane write-back buffer. Each lane's final data is resolved,
//            including load extension, and the register writes are drained in
//            program order through one register-file port.
// Options  : WB_BYPASS_EN builds the youngest-match bypass lookup.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 2,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [LANES-1:0]        in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_alu_result,
    input  logic [LANES*DATA_W-1:0] in_mem_data,
    input  logic [LANES-1:0]        in_mem_to_reg,
    input  logic [LANES*3-1:0]      in_load_type,
    input  logic [LANES*2-1:0]      in_byte_off,
    input  logic [LANES*ADDR_W-1:0] in_write_reg,
    input  logic [LANES-1:0]        in_reg_write,
    output logic                    reg_write_en,
    output logic [ADDR_W-1:0]       reg_write_addr,
    output logic [DATA_W-1:0]       reg_write_data,
    output logic [$clog2(DEPTH):0]  count,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_hit,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_LANES = c_CNT_W'(LANES);

    logic [ADDR_W-1:0]  r_addr_q [DEPTH];
    logic [DATA_W-1:0]  r_data_q [DEPTH];
    logic [c_PTR_W-1:0] r_head_q;
    logic [c_PTR_W-1:0] r_tail_q;
    logic [c_CNT_W-1:0] r_count_q;
    logic [c_CNT_W-1:0] w_count_d;

    logic [LANES-1:0]   w_keep;
    logic [DATA_W-1:0]  w_lane_data [LANES];
    logic [c_PTR_W-1:0] w_lane_slot [LANES];
    logic [c_CNT_W-1:0] w_enq_cnt;
    logic               w_accept;
    logic               w_pop;

    function automatic logic [31:0] f_load_extend(
        input logic [31:0] word,
        input logic [2:0]  ltype,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (ltype)
            3'd1:    f_load_extend = {{24{b[7]}}, b};
            3'd2:    f_load_extend = {24'd0, b};
            3'd3:    f_load_extend = {{16{h[15]}}, h};
            3'd4:    f_load_extend = {16'd0, h};
            default: f_load_extend = word;
        endcase
    endfunction

    // Backpressure uses only the registered count; a same-cycle pop is not credited.
    assign in_ready = (c_DEPTH - r_count_q) >= c_LANES;
    assign w_accept = in_ready & (|in_valid);

    always_comb begin
        w_enq_cnt = '0;
        w_keep    = '0;
        for (int l = 0; l < LANES; l++) begin
            w_keep[l] = in_valid[l] & in_reg_write[l]
                      & (in_write_reg[l*ADDR_W +: ADDR_W] != '0);
            w_lane_data[l] = in_mem_to_reg[l]
                ? f_load_extend(in_mem_data[l*DATA_W +: DATA_W],
                                in_load_type[l*3 +: 3],
                                in_byte_off[l*2 +: 2])
                : in_alu_result[l*DATA_W +: DATA_W];
            // Surviving lanes pack densely from tail in lane order.
            w_lane_slot[l] = r_tail_q + w_enq_cnt[c_PTR_W-1:0];
            if (w_keep[l]) begin
                w_enq_cnt = w_enq_cnt + c_CNT_W'(1);
            end
        end
        if (!w_accept) begin
            w_enq_cnt = '0;
        end
    end

    assign reg_write_en   = (r_count_q != '0) & ~stall & ~rst;
    assign w_pop          = reg_write_en;
    assign reg_write_addr = reg_write_en ? r_addr_q[r_head_q] : '0;
    assign reg_write_data = reg_write_en ? r_data_q[r_head_q] : '0;
    assign w_count_d      = r_count_q + w_enq_cnt - c_CNT_W'(w_pop);
    assign count          = r_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            if (w_pop) begin
                r_head_q <= r_head_q + c_PTR_W'(1);
            end
            r_tail_q  <= r_tail_q + w_enq_cnt[c_PTR_W-1:0];
            r_count_q <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_keep[l]) begin
                    r_addr_q[w_lane_slot[l]] <= in_write_reg[l*ADDR_W +: ADDR_W];
                    r_data_q[w_lane_slot[l]] <= w_lane_data[l];
                end
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_CNT_W'(i) < r_count_q) && (rd_addr != '0)
                && (r_addr_q[r_head_q + c_PTR_W'(i)] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = r_data_q[r_head_q + c_PTR_W'(i)];
            end
        end
    end
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^rd_addr;
    assign rd_hit           = 1'b0;
    assign rd_data          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_buffer.sv
`default_nettype none
// Testbench for wb_commit_buffer: load-extension vector table, scoreboard of
// expected register writes, and hand-written ordering/backpressure/reset sequences.
module tb_wb_commit_buffer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  in_valid;
    logic        in_ready;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_data;
    logic [1:0]  in_mem_to_reg;
    logic [5:0]  in_load_type;
    logic [3:0]  in_byte_off;
    logic [9:0]  in_write_reg;
    logic [1:0]  in_reg_write;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic [3:0]  count;
    logic [4:0]  rd_addr;
    logic        rd_hit;
    logic [31:0] rd_data;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_commit_buffer #(.DATA_W(32), .ADDR_W(5), .LANES(2), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_mem_to_reg(in_mem_to_reg), .in_load_type(in_load_type),
        .in_byte_off(in_byte_off), .in_write_reg(in_write_reg),
        .in_reg_write(in_reg_write),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .count(count),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Independent reference for load resolution, written with shifts.
    function automatic logic [31:0] m_res(input logic m2r, input logic [2:0] lt,
                                          input logic [1:0] off, input logic [31:0] alu,
                                          input logic [31:0] mem);
        logic [31:0] sh;
        if (!m2r) return alu;
        case (lt)
            3'd1, 3'd2: begin
                sh = mem >> (8 * off);
                if (lt == 3'd1 && sh[7]) return sh | 32'hFFFF_FF00 & 32'hFFFF_FF00 | (sh & 32'hFF);
                return sh & 32'h0000_00FF;
            end
            3'd3, 3'd4: begin
                sh = mem >> (off[1] ? 16 : 0);
                if (lt == 3'd3 && sh[15]) return 32'hFFFF_0000 | (sh & 32'hFFFF);
                return sh & 32'h0000_FFFF;
            end
            default: return mem;
        endcase
    endfunction

    // Scoreboard: {addr, data} pushed when a group is accepted, popped on writes.
    logic [36:0] sb[$];
    int m_count = 0;
    int m_pop;
    int m_enq;

    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            m_count = 0;
        end else begin
            m_pop = (m_count != 0 && !stall) ? 1 : 0;
            m_enq = 0;
            if ((8 - m_count) >= 2 && in_valid != 2'b00) begin
                for (int l = 0; l < 2; l++) begin
                    if (in_valid[l] && in_reg_write[l] && in_write_reg[l*5 +: 5] != 5'd0) begin
                        sb.push_back({in_write_reg[l*5 +: 5],
                                      m_res(in_mem_to_reg[l], in_load_type[l*3 +: 3],
                                            in_byte_off[l*2 +: 2], in_alu_result[l*32 +: 32],
                                            in_mem_data[l*32 +: 32])});
                        m_enq++;
                    end
                end
            end
            m_count = m_count + m_enq - m_pop;
        end
    end

    logic [36:0] mon_exp;
    always @(negedge clk) begin
        chk("wr_en", {63'd0, reg_write_en}, {63'd0, (m_count != 0 && !stall && !rst)});
        if (reg_write_en) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: write addr %h data %h with nothing expected", reg_write_addr, reg_write_data);
            end else begin
                mon_exp = sb.pop_front();
                chk("sb_addr", {59'd0, reg_write_addr}, {59'd0, mon_exp[36:32]});
                chk("sb_data", {32'd0, reg_write_data}, {32'd0, mon_exp[31:0]});
            end
        end else begin
            chk("idle_addr", {59'd0, reg_write_addr}, 64'd0);
            chk("idle_data", {32'd0, reg_write_data}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = '0; in_alu_result = '0; in_mem_data = '0; in_mem_to_reg = '0;
        in_load_type = '0; in_byte_off = '0; in_write_reg = '0; in_reg_write = '0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] r, input logic [31:0] alu,
                            input logic [31:0] mem, input logic m2r, input logic [2:0] lt,
                            input logic [1:0] off, input logic we);
        in_valid[l] = 1'b1;
        in_alu_result[l*32 +: 32] = alu;
        in_mem_data[l*32 +: 32] = mem;
        in_mem_to_reg[l] = m2r;
        in_load_type[l*3 +: 3] = lt;
        in_byte_off[l*2 +: 2] = off;
        in_write_reg[l*5 +: 5] = r;
        in_reg_write[l] = we;
    endtask

    typedef struct {
        logic        m2r;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 3'd1, 2'd3, 32'h0, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[1]  = '{1'b1, 3'd2, 2'd1, 32'h0, 32'h80FF7F01, 32'h0000007F};
        vecs[2]  = '{1'b1, 3'd3, 2'd2, 32'h0, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[3]  = '{1'b1, 3'd4, 2'd0, 32'h0, 32'h80FF7F01, 32'h00007F01};
        vecs[4]  = '{1'b1, 3'd0, 2'd0, 32'h0, 32'h80FF7F01, 32'h80FF7F01};
        vecs[5]  = '{1'b1, 3'd1, 2'd2, 32'h0, 32'h80FF7F01, 32'hFFFFFFFF};
        vecs[6]  = '{1'b1, 3'd1, 2'd1, 32'h0, 32'h80FF7F01, 32'h0000007F};
        vecs[7]  = '{1'b1, 3'd4, 2'd3, 32'h0, 32'h80FF7F01, 32'h000080FF};
        vecs[8]  = '{1'b1, 3'd5, 2'd1, 32'h0, 32'h80FF7F01, 32'h80FF7F01};
        vecs[9]  = '{1'b0, 3'd1, 2'd3, 32'hDEADBEEF, 32'h80FF7F01, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 3'd2, 2'd3, 32'h0, 32'h80FF7F01, 32'h00000080};

        rst = 1'b1; stall = 1'b0; rd_addr = '0;
        clear_in();
        tick();
        tick();
        @(negedge clk);
        chk("rst_count", {60'd0, count}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_en", {63'd0, reg_write_en}, 64'd0);
        chk("rst_hit", {63'd0, rd_hit}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        tick();
        rst = 1'b0;

        // Single lane, one-cycle latency to the write port.
        set_lane(0, 5'd5, 32'h00001234, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        tick();
        clear_in();
        @(negedge clk);
        chk("single_en", {63'd0, reg_write_en}, 64'd1);
        chk("single_addr", {59'd0, reg_write_addr}, 64'd5);
        chk("single_data", {32'd0, reg_write_data}, 64'h1234);
        tick();
        @(negedge clk);
        chk("single_drained", {60'd0, count}, 64'd0);
        tick();

        for (int i = 0; i < 11; i++) begin
            set_lane(0, 5'd9, vecs[i].alu, vecs[i].mem, vecs[i].m2r, vecs[i].lt, vecs[i].off, 1'b1);
            tick();
            clear_in();
            @(negedge clk);
            chk($sformatf("vec%0d", i), {32'd0, reg_write_data}, {32'd0, vecs[i].exp});
            tick();
        end

        // Same-register pair: bypass returns the younger lane, drain keeps order.
        stall = 1'b1;
        rd_addr = 5'd3;
        set_lane(0, 5'd3, 32'd1, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        set_lane(1, 5'd3, 32'd2, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        tick();
        clear_in();
        @(negedge clk);
        chk("pair_count", {60'd0, count}, 64'd2);
        chk("byp_hit", {63'd0, rd_hit}, {63'd0, BYP});
        chk("byp_data", {32'd0, rd_data}, BYP ? 64'd2 : 64'd0);
        rd_addr = 5'd0;
        #1;
        chk("byp_r0_hit", {63'd0, rd_hit}, 64'd0);
        tick();
        stall = 1'b0;
        @(negedge clk);
        chk("order_first", {32'd0, reg_write_data}, 64'd1);
        tick();
        @(negedge clk);
        chk("order_second", {32'd0, reg_write_data}, 64'd2);
        tick();
        @(negedge clk);
        chk("pair_drained", {60'd0, count}, 64'd0);
        tick();

        // Fill to DEPTH under stall, offer an extra group, then drain.
        stall = 1'b1;
        for (int g = 0; g < 4; g++) begin
            set_lane(0, 5'(8 + 2*g), 32'(100 + 2*g), 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
            set_lane(1, 5'(9 + 2*g), 32'(101 + 2*g), 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
            tick();
        end
        set_lane(0, 5'd20, 32'hAAAA, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        set_lane(1, 5'd21, 32'hBBBB, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        rd_addr = 5'd15;
        @(negedge clk);
        chk("full_count", {60'd0, count}, 64'd8);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        chk("full_byp", {32'd0, rd_data}, BYP ? 64'd107 : 64'd0);
        tick();
        clear_in();
        rd_addr = 5'd0;
        @(negedge clk);
        chk("full_hold", {60'd0, count}, 64'd8);
        tick();
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_en", i), {63'd0, reg_write_en}, 64'd1);
            chk($sformatf("drain%0d_addr", i), {59'd0, reg_write_addr}, 64'(8 + i));
            chk($sformatf("drain%0d_ready", i), {63'd0, in_ready}, ((8 - i) <= 6) ? 64'd1 : 64'd0);
            tick();
        end
        @(negedge clk);
        chk("drain_empty", {60'd0, count}, 64'd0);
        tick();

        // Filtered lanes are consumed without queuing anything.
        set_lane(0, 5'd0, 32'h55, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        set_lane(1, 5'd7, 32'h66, 32'h0, 1'b0, 3'd0, 2'd0, 1'b0);
        tick();
        clear_in();
        @(negedge clk);
        chk("filt_count", {60'd0, count}, 64'd0);
        chk("filt_en", {63'd0, reg_write_en}, 64'd0);
        tick();

        // Reset with a partly filled buffer discards everything.
        stall = 1'b1;
        set_lane(0, 5'd1, 32'h11, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        set_lane(1, 5'd2, 32'h22, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        tick();
        set_lane(0, 5'd3, 32'h33, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        set_lane(1, 5'd4, 32'h44, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1);
        tick();
        clear_in();
        stall = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("mrst_count", {60'd0, count}, 64'd0);
        chk("mrst_ready", {63'd0, in_ready}, 64'd1);
        chk("mrst_en", {63'd0, reg_write_en}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_en", {63'd0, reg_write_en}, 64'd0);
        chk("sb_leftover", 64'(sb.size()), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_commit_buffer.md
Name: wb_commit_buffer

Overview:
- Parametrised successor to the single-lane write-back stage.
- Accepts up to LANES completed results per cycle from the memory-access stage and resolves each result's final data, including mem_to_reg selection and load byte/halfword extension.
- Queues register writes in a FIFO and drains them in program order through one register-file write port.
- Optionally exposes a youngest-match bypass lookup so decode can read values still waiting in the buffer.

Parameters:
- DATA_W, 32, register data width (fixed at 32 for load extension).
- ADDR_W, 5, register address width.
- LANES, 2, results offered per cycle; lane 0 is oldest.
- DEPTH, 8, FIFO entries; power of 2, DEPTH >= LANES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall  in  1  freezes draining; enqueue is still allowed.
- in_valid  in  LANES  per-lane result valid.
- in_ready  out  1  buffer can accept a full LANES group this cycle.
- in_alu_result  in  LANES*DATA_W  ALU result per lane.
- in_mem_data  in  LANES*DATA_W  raw memory word per lane.
- in_mem_to_reg  in  LANES  1 selects loaded data, 0 selects ALU result.
- in_load_type  in  LANES*3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU.
- in_byte_off  in  LANES*2  address bits [1:0] of the load.
- in_write_reg  in  LANES*ADDR_W  destination register.
- in_reg_write  in  LANES  register write enable.
- reg_write_en  out  1  register-file write strobe.
- reg_write_addr  out  ADDR_W  register-file write address.
- reg_write_data  out  DATA_W  register-file write data.
- count  out  $clog2(DEPTH)+1  occupied entries.
- rd_addr  in  ADDR_W  bypass lookup address.
- rd_hit  out  1  a pending entry matches rd_addr.
- rd_data  out  DATA_W  data of the youngest matching entry.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset: count=0, head/tail pointers=0; reg_write_en=0, reg_write_addr=0, reg_write_data=0, rd_hit=0, rd_data=0. While rst is high, reg_write_en is forced 0. Reset mid-operation discards all entries with no further writes.
- in_ready = (DEPTH - count) >= LANES, computed from registered count only; a pop in the same cycle is not credited.
- Accept: a group is consumed on a cycle where in_ready=1 and in_valid!=0. When in_ready=0, inputs are ignored and nothing is enqueued; upstream must hold the group.
- Enqueue filter: a lane is enqueued only if in_valid & in_reg_write & (in_write_reg != 0). Filtered lanes are consumed silently.
- Ordering: surviving lanes are packed into consecutive entries in lane order, lane 0 first, at tail.
- Data resolution (combinational, before enqueue): mem_to_reg=0 gives alu_result. mem_to_reg=1 gives the extended load.
  - Byte k = mem_data[8k+7:8k] (little-endian).
  - LB/LBU select byte byte_off, sign- or zero-extended.
  - LH/LHU select halfword byte_off[1]; byte_off[0] is ignored.
  - LW and load types 5-7 pass the full word.
- Drain: reg_write_en = (count!=0) & !stall & !rst. reg_write_addr/data come from the head entry and are driven 0 when reg_write_en=0. The head pops on the rising edge when reg_write_en=1. Maximum one write per cycle.
- Latency: an entry accepted at edge N is written in cycle N+1 if it reaches head and stall=0.
- Simultaneous enqueue and pop: count_next = count + enq_cnt - pop. Pointers wrap modulo DEPTH.
- Full: count=DEPTH gives in_ready=0. Empty: reg_write_en=0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: rd_hit=1 when any valid entry has write_reg==rd_addr and rd_addr!=0. rd_data is the youngest such entry (closest to tail). Lookup is combinational over FIFO contents only; same-cycle inputs are not included.
- Undefined: rd_hit=0 and rd_data=0 constantly, and no comparator logic is built.

Test Plan:
- Reset: hold rst 2 cycles with FIFO partly filled -> count=0, in_ready=1, reg_write_en=0, addr/data=0.
- Single lane: lane0 valid, reg_write=1, write_reg=5, alu=0x00001234, mem_to_reg=0 -> next cycle reg_write_en=1, addr=5, data=0x00001234; then count=0.
- Load extension, mem_data=0x80FF7F01:
  - LB off3 -> 0xFFFFFF80.
  - LBU off1 -> 0x0000007F.
  - LH off2 -> 0xFFFF80FF.
  - LHU off0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Ordering and bypass: one group writes lane0 r3=1 and lane1 r3=2 with stall=1 -> rd_addr=3 gives rd_hit=1, rd_data=2. Release stall -> write r3=1, then r3=2 on consecutive cycles.
- Full/backpressure: stall=1, 4 groups of 2 lanes (DEPTH=8) -> count=8, in_ready=0, a 5th group is ignored. Release stall -> 8 in-order writes in 8 consecutive cycles; in_ready returns to 1 when count<=6.
- Filtering: lanes with write_reg=0 or reg_write=0 -> count unchanged, no write. rd_addr=0 -> rd_hit=0.
